// File: rtl/ctrl_hazard_stage.sv
// ID/EX pipeline register with main control decode, load-use hazard
// detection, a sticky illegal-opcode flag and a saturating stall counter.
module ctrl_hazard_stage #(
   parameter int REG_W      = 5,
   parameter int ALUOP_W    = 3,
   parameter int CNT_W      = 16,
   parameter int ENABLE_BNE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [5:0]         id_opcode,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic               flush,
   input  logic               cnt_clr,
   output logic               ex_valid,
   output logic               ex_RegWrite,
   output logic               ex_MemRead,
   output logic               ex_MemWrite,
   output logic               ex_ALUSrc,
   output logic               ex_Branch,
   output logic               ex_BranchNe,
   output logic               ex_Jump,
   output logic [1:0]         ex_RegDst,
   output logic [1:0]         ex_MemtoReg,
   output logic [ALUOP_W-1:0] ex_ALUOp,
   output logic [REG_W-1:0]   ex_rt,
   output logic               stall,
   output logic               illegal,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_RF  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic               reg_write;
      logic               mem_read;
      logic               mem_write;
      logic               alu_src;
      logic               branch;
      logic               branch_ne;
      logic               jump;
      logic [1:0]         reg_dst;
      logic [1:0]         mem_to_reg;
      logic [ALUOP_W-1:0] alu_op;
   } ctrl_t;

   ctrl_t            dec;
   logic             dec_ok;
   ctrl_t            ex_q;
   logic             bubble;

   // Main control decode; every unlisted field stays 0 so no X leaves the block
   always_comb begin
      dec    = '0;
      dec_ok = 1'b1;
      case (id_opcode)
         OP_R: begin
            dec.reg_dst = 2'b01; dec.reg_write = 1'b1; dec.alu_op[2:0] = ALU_RF;
         end
         OP_ADDI: begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op[2:0] = ALU_ADD;
         end
         OP_ANDI: begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op[2:0] = ALU_AND;
         end
         OP_ORI: begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op[2:0] = ALU_OR;
         end
         OP_SLTI: begin
            dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op[2:0] = ALU_SLT;
         end
         OP_LW: begin
            dec.alu_src = 1'b1; dec.mem_to_reg = 2'b01; dec.reg_write = 1'b1;
            dec.mem_read = 1'b1; dec.alu_op[2:0] = ALU_ADD;
         end
         OP_SW: begin
            dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op[2:0] = ALU_ADD;
         end
         OP_BEQ: begin
            dec.branch = 1'b1; dec.alu_op[2:0] = ALU_SUB;
         end
         OP_BNE: begin
            if (ENABLE_BNE != 0) begin
               dec.branch_ne = 1'b1; dec.alu_op[2:0] = ALU_SUB;
            end else begin
               dec_ok = 1'b0;
            end
         end
         OP_JAL: begin
            dec.reg_dst = 2'b10; dec.mem_to_reg = 2'b10; dec.reg_write = 1'b1;
            dec.jump = 1'b1;
         end
         OP_J: dec.jump = 1'b1;
         default: dec_ok = 1'b0;
      endcase
   end

   // Load-use hazard: the load in EX targets a register the ID instruction reads
   assign stall = id_valid & ex_valid & ex_q.mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush;

   // Anything other than a legal, valid, unsquashed, unstalled instruction is a bubble
   assign bubble = flush | stall | ~id_valid | ~dec_ok;

   // ID/EX register; a bubble clears control so a stall lasts a single cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q     <= '0;
         ex_valid <= 1'b0;
         ex_rt    <= '0;
      end else if (bubble) begin
         ex_q     <= '0;
         ex_valid <= 1'b0;
         ex_rt    <= '0;
      end else begin
         ex_q     <= dec;
         ex_valid <= 1'b1;
         ex_rt    <= id_rt;
      end
   end

   // Sticky flag: set only when an unrecognised opcode would otherwise have issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  illegal <= 1'b0;
      else if (id_valid & ~flush & ~stall & ~dec_ok) illegal <= 1'b1;
   end

   // Saturating stall counter; clear beats a simultaneous increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              stall_cnt <= '0;
      else if (cnt_clr)                        stall_cnt <= '0;
      else if (stall && stall_cnt != CNT_MAX)  stall_cnt <= stall_cnt + 1'b1;
   end

   assign ex_RegWrite = ex_q.reg_write;
   assign ex_MemRead  = ex_q.mem_read;
   assign ex_MemWrite = ex_q.mem_write;
   assign ex_ALUSrc   = ex_q.alu_src;
   assign ex_Branch   = ex_q.branch;
   assign ex_BranchNe = ex_q.branch_ne;
   assign ex_Jump     = ex_q.jump;
   assign ex_RegDst   = ex_q.reg_dst;
   assign ex_MemtoReg = ex_q.mem_to_reg;
   assign ex_ALUOp    = ex_q.alu_op;

endmodule

// File: tb/tb_ctrl_hazard_stage.sv
// Directed bench: a default instance and a CNT_W=2 / ENABLE_BNE=0 / ALUOP_W=4
// instance share the same stimulus.
module tb_ctrl_hazard_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, flush, cnt_clr;
   logic [5:0] id_opcode;
   logic [4:0] id_rs, id_rt;

   logic        a_valid, a_rw, a_mr, a_mw, a_as, a_br, a_bne, a_j, a_stall, a_ill;
   logic [1:0]  a_rd, a_m2r;
   logic [2:0]  a_aop;
   logic [4:0]  a_rt;
   logic [15:0] a_cnt;

   logic        b_valid, b_rw, b_mr, b_mw, b_as, b_br, b_bne, b_j, b_stall, b_ill;
   logic [1:0]  b_rd, b_m2r;
   logic [3:0]  b_aop;
   logic [4:0]  b_rt;
   logic [1:0]  b_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ctrl_hazard_stage dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .cnt_clr(cnt_clr),
      .ex_valid(a_valid), .ex_RegWrite(a_rw), .ex_MemRead(a_mr), .ex_MemWrite(a_mw),
      .ex_ALUSrc(a_as), .ex_Branch(a_br), .ex_BranchNe(a_bne), .ex_Jump(a_j),
      .ex_RegDst(a_rd), .ex_MemtoReg(a_m2r), .ex_ALUOp(a_aop), .ex_rt(a_rt),
      .stall(a_stall), .illegal(a_ill), .stall_cnt(a_cnt));

   ctrl_hazard_stage #(.CNT_W(2), .ENABLE_BNE(0), .ALUOP_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush), .cnt_clr(cnt_clr),
      .ex_valid(b_valid), .ex_RegWrite(b_rw), .ex_MemRead(b_mr), .ex_MemWrite(b_mw),
      .ex_ALUSrc(b_as), .ex_Branch(b_br), .ex_BranchNe(b_bne), .ex_Jump(b_j),
      .ex_RegDst(b_rd), .ex_MemtoReg(b_m2r), .ex_ALUOp(b_aop), .ex_rt(b_rt),
      .stall(b_stall), .illegal(b_ill), .stall_cnt(b_cnt));

   // Control word: RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,BranchNe,Jump,ALUOp
   wire [13:0] a_ctl = {a_rd, a_as, a_m2r, a_rw, a_mr, a_mw, a_br, a_bne, a_j, a_aop};
   wire [14:0] b_ctl = {b_rd, b_as, b_m2r, b_rw, b_mr, b_mw, b_br, b_bne, b_j, b_aop};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic fl, input logic clr);
      id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; flush = fl; cnt_clr = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   logic [5:0]  ops [11];
   logic [13:0] exps[11];

   initial begin
      ops[0]  = 6'b000000; exps[0]  = 14'b01_0_00_1_0_0_0_0_0_010;
      ops[1]  = 6'b001000; exps[1]  = 14'b00_1_00_1_0_0_0_0_0_000;
      ops[2]  = 6'b001100; exps[2]  = 14'b00_1_00_1_0_0_0_0_0_011;
      ops[3]  = 6'b001101; exps[3]  = 14'b00_1_00_1_0_0_0_0_0_100;
      ops[4]  = 6'b001010; exps[4]  = 14'b00_1_00_1_0_0_0_0_0_101;
      ops[5]  = 6'b100011; exps[5]  = 14'b00_1_01_1_1_0_0_0_0_000;
      ops[6]  = 6'b101011; exps[6]  = 14'b00_1_00_0_0_1_0_0_0_000;
      ops[7]  = 6'b000100; exps[7]  = 14'b00_0_00_0_0_0_1_0_0_001;
      ops[8]  = 6'b000101; exps[8]  = 14'b00_0_00_0_0_0_0_1_0_001;
      ops[9]  = 6'b000011; exps[9]  = 14'b10_0_10_1_0_0_0_0_1_000;
      ops[10] = 6'b000010; exps[10] = 14'b00_0_00_0_0_0_0_0_1_000;

      rst_n = 1'b0;
      drive(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0, 1'b0);
      #12;
      chk("rst_ctl",   {18'd0, a_ctl}, 32'd0);
      chk("rst_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_cnt",   {16'd0, a_cnt}, 32'd0);
      chk("rst_ill",   {31'd0, a_ill}, 32'd0);
      chk("rst_stall", {31'd0, a_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table sweep: rs=1 never matches a previous rt (>=10), so no hazards
      for (int k = 0; k < 11; k++) begin
         drive(1'b1, ops[k], 5'd1, 5'(k + 10), 1'b0, 1'b0);
         tick();
         chk($sformatf("a_ctl_%0d", k), {18'd0, a_ctl}, {18'd0, exps[k]});
         chk($sformatf("a_valid_%0d", k), {31'd0, a_valid}, 32'd1);
         chk($sformatf("a_rt_%0d", k), {27'd0, a_rt}, 32'(k + 10));
         if (k == 8) begin
            chk("b_bne_ctl",   {17'd0, b_ctl}, 32'd0);
            chk("b_bne_valid", {31'd0, b_valid}, 32'd0);
            chk("b_bne_ill",   {31'd0, b_ill}, 32'd1);
         end else begin
            chk($sformatf("b_ctl_%0d", k), {17'd0, b_ctl},
                {17'd0, exps[k][13:3], 1'b0, exps[k][2:0]});
         end
         if (k == 9) begin
            chk("b_ill_held", {31'd0, b_ill}, 32'd1);
            #1 rst_n = 1'b0;
            #1;
            chk("mid_rst_a_ctl",   {18'd0, a_ctl}, 32'd0);
            chk("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
            chk("mid_rst_a_rt",    {27'd0, a_rt}, 32'd0);
            chk("mid_rst_b_ill",   {31'd0, b_ill}, 32'd0);
            chk("mid_rst_b_ctl",   {17'd0, b_ctl}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      // Unknown opcode: bubble, sticky illegal
      drive(1'b1, 6'b111111, 5'd1, 5'd2, 1'b0, 1'b0);
      tick();
      chk("ill_valid", {31'd0, a_valid}, 32'd0);
      chk("ill_ctl",   {18'd0, a_ctl}, 32'd0);
      chk("ill_set",   {31'd0, a_ill}, 32'd1);
      drive(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0, 1'b0);
      tick();
      chk("ill_hold",  {31'd0, a_ill}, 32'd1);
      chk("ill_next_valid", {31'd0, a_valid}, 32'd1);

      // Load-use: lw rt=8 then add rs=8
      reset_pulse();
      drive(1'b1, 6'b100011, 5'd1, 5'd8, 1'b0, 1'b0);
      tick();
      drive(1'b1, 6'b000000, 5'd8, 5'd9, 1'b0, 1'b0);
      #1;
      chk("lu_stall", {31'd0, a_stall}, 32'd1);
      tick();
      chk("lu_bubble_valid", {31'd0, a_valid}, 32'd0);
      chk("lu_bubble_ctl",   {18'd0, a_ctl}, 32'd0);
      chk("lu_stall_gone",   {31'd0, a_stall}, 32'd0);
      chk("lu_cnt_a",        {16'd0, a_cnt}, 32'd1);
      chk("lu_cnt_b",        {30'd0, b_cnt}, 32'd1);
      tick();
      chk("lu_add_ctl",   {18'd0, a_ctl}, {18'd0, exps[0]});
      chk("lu_add_rt",    {27'd0, a_rt}, 32'd9);
      chk("lu_add_valid", {31'd0, a_valid}, 32'd1);

      // lw to $zero never stalls
      drive(1'b1, 6'b100011, 5'd1, 5'd0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 6'b000000, 5'd0, 5'd3, 1'b0, 1'b0);
      #1;
      chk("zero_stall", {31'd0, a_stall}, 32'd0);
      tick();
      chk("zero_add_valid", {31'd0, a_valid}, 32'd1);
      chk("zero_add_rt",    {27'd0, a_rt}, 32'd3);

      // Dependent add with flush: no stall, bubble, count unchanged
      drive(1'b1, 6'b100011, 5'd1, 5'd8, 1'b0, 1'b0);
      tick();
      drive(1'b1, 6'b000000, 5'd8, 5'd9, 1'b1, 1'b0);
      #1;
      chk("fl_stall", {31'd0, a_stall}, 32'd0);
      tick();
      chk("fl_valid", {31'd0, a_valid}, 32'd0);
      chk("fl_ctl",   {18'd0, a_ctl}, 32'd0);
      chk("fl_cnt",   {16'd0, a_cnt}, 32'd1);

      // Clear, then lw rs=rt=8 repeated: stall on every second edge
      drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0, 1'b1);
      tick();
      chk("clr_cnt", {16'd0, a_cnt}, 32'd0);
      drive(1'b1, 6'b100011, 5'd8, 5'd8, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      chk("sat_cnt_a", {16'd0, a_cnt}, 32'd5);
      chk("sat_cnt_b", {30'd0, b_cnt}, 32'd3);
      tick();
      cnt_clr = 1'b1;
      #1;
      chk("clr_win_stall", {31'd0, a_stall}, 32'd1);
      tick();
      chk("clr_win_a", {16'd0, a_cnt}, 32'd0);
      chk("clr_win_b", {30'd0, b_cnt}, 32'd0);
      cnt_clr = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctrl_hazard_stage.md
CTRL_HAZARD_STAGE -- requirements
Module: ctrl_hazard_stage

Interface
REQ-001 Parameter REG_W, default 5, SHALL set register-address width.
REQ-002 Parameter ALUOP_W, default 3 (legal >=3), SHALL set ex_ALUOp width.
REQ-003 Parameter CNT_W, default 16, SHALL set stall_cnt width.
REQ-004 Parameter ENABLE_BNE, default 1, SHALL enable bne decode; 0 makes bne illegal.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst_n  in  1  async active-low reset.
REQ-008 id_valid  in  1  IF/ID holds a real instruction.
REQ-009 id_opcode  in  6  instruction[31:26].
REQ-010 id_rs, id_rt  in  REG_W each  source register fields.
REQ-011 flush  in  1  branch/jump taken; squash the ID instruction.
REQ-012 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-013 ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_Branch, ex_BranchNe, ex_Jump  out  1 each  registered ID/EX control.
REQ-014 ex_RegDst, ex_MemtoReg  out  2 each; ex_ALUOp  out  ALUOP_W; ex_rt  out  REG_W.
REQ-015 stall  out  1  combinational; freeze PC and IF/ID this cycle.
REQ-016 illegal  out  1  sticky illegal-opcode flag.
REQ-017 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 Decode SHALL be registered: fields presented in cycle N appear on ex_* after edge N+1 (1-cycle latency).
REQ-019 ALUOp encodings SHALL be: 000 add, 001 sub, 010 R-funct, 011 and, 100 or, 101 slt; upper bits zero when ALUOP_W>3.
REQ-020 Decode table (RegDst/ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite/Branch/BranchNe/Jump/ALUOp) SHALL be:
 - 000000 R: 01/0/00/1/0/0/0/0/0/010
 - 001000 addi: 00/1/00/1/0/0/0/0/0/000; 001100 andi: .../011; 001101 ori: .../100; 001010 slti: .../101
 - 100011 lw: 00/1/01/1/1/0/0/0/0/000
 - 101011 sw: 00/1/00/0/0/1/0/0/0/000
 - 000100 beq: 00/0/00/0/0/0/1/0/0/001
 - 000101 bne (ENABLE_BNE=1): 00/0/00/0/0/0/0/1/0/001
 - 000011 jal: 10/0/10/1/0/0/0/0/1/000; 000010 j: all zero except Jump=1.
REQ-021 No output SHALL ever be driven X; former don't-cares SHALL be 0.
REQ-022 A bubble SHALL load all ex_* control fields, ex_rt and ex_valid as 0.
REQ-023 stall SHALL equal id_valid & ex_valid & ex_MemRead & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt) & !flush.
REQ-024 Priority each edge SHALL be flush > stall > normal; flush or stall loads a bubble; normal loads the decode with ex_valid=id_valid.
REQ-025 id_valid=0 SHALL load a bubble.
REQ-026 Unrecognised opcode with id_valid=1, no flush, no stall SHALL load a bubble and set illegal to 1, which holds until reset.
REQ-027 stall_cnt SHALL increment by 1 on each edge where stall=1, and saturate at 2^CNT_W-1.
REQ-028 cnt_clr=1 SHALL load stall_cnt=0 and SHALL win over a simultaneous increment.
REQ-029 A stall SHALL last exactly one cycle per lw, because the bubble clears ex_MemRead.

Reset
REQ-030 rst_n low SHALL immediately force all ex_* outputs, illegal and stall_cnt to 0, independent of clk; stall is then 0.
REQ-031 Reset asserted mid-stall SHALL discard the pending instruction state; the first edge after release SHALL decode normally.

Verification
REQ-032 lw $t0 (rt=8), then add with rs=8 -> stall=1 for one cycle, bubble in EX, add reaches EX one cycle later, stall_cnt=1.
REQ-033 lw rt=0, then add with rs=0 -> stall=0, no bubble.
REQ-034 Dependent add after lw with flush=1 in the same cycle -> stall=0, bubble loaded, stall_cnt unchanged.
REQ-035 opcode 000101 with ENABLE_BNE=0 -> bubble, illegal=1 and held; with ENABLE_BNE=1 -> ex_BranchNe=1, ex_ALUOp=001.
REQ-036 CNT_W=2 with 5 forced stalls -> stall_cnt=3; cnt_clr concurrent with a stall -> 0.
REQ-037 Drive each table opcode in sequence -> ex_* matches REQ-020 one edge later; assert rst_n low mid-sequence -> all outputs 0 asynchronously.
